// File: rtl/result_display_scan.sv
// Keeps a NUM_DIGITS-deep history of OCR results and scans it onto an active-low 7-segment display.
// Optional build macro DISPLAY_GHOST_BLANK_EN blanks the first 2 clocks of every digit slot.
module result_display_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                result_valid,
    input  logic [3:0]                          result_in,
    input  logic                                clear,
    output logic [NUM_DIGITS-1:0]               an,
    output logic [6:0]                          seg,
    output logic                                dp,
    output logic [$clog2(NUM_DIGITS+1)-1:0]     history_count
);

    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int SCAN_W = $clog2(SCAN_DIV);

    logic [NUM_DIGITS-1:0] valid_q, valid_d;
    logic [3:0]            code_q [NUM_DIGITS];
    logic [3:0]            code_d [NUM_DIGITS];
    logic [CNT_W-1:0]      count_q, count_d;
    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  scan_wrap;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        case (code)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            4'd10:   return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    // History: clear takes effect first so a same-cycle result survives as the only entry.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        valid_d = valid_q;
        code_d  = code_q;
        count_d = count_q;
        if (clear) begin
            valid_d = '0;
            count_d = '0;
        end
        if (result_valid) begin
            valid_d = {valid_d[NUM_DIGITS-2:0], 1'b1};
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                code_d[i] = code_q[i-1];
            end
            code_d[0] = result_in;
            if (count_d != CNT_W'(NUM_DIGITS)) begin
                count_d = count_d + CNT_W'(1);
            end
        end
    end

    always_comb begin
        scan_wrap   = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        digit_idx_d = digit_idx_q;
        if (scan_wrap) begin
            digit_idx_d = (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        an_d  = ~(NUM_DIGITS'(1) << digit_idx_q);
        seg_d = valid_q[digit_idx_q] ? seg_decode(code_q[digit_idx_q]) : 7'h7F;
        dp_d  = (digit_idx_q == '0) && valid_q[0];
`ifdef DISPLAY_GHOST_BLANK_EN
        if (scan_cnt_q < SCAN_W'(2)) begin
            an_d  = '1;
            seg_d = 7'h7F;
            dp_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            valid_q     <= '0;
            count_q     <= '0;
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
            an_q        <= '1;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            count_q     <= count_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    // NOTE: the code storage has no reset; the valid bits alone decide whether an entry is shown.
    always_ff @(posedge clk) begin
        code_q <= code_d;
    end

    assign an            = an_q;
    assign seg           = seg_q;
    assign dp            = dp_q;
    assign history_count = count_q;

endmodule

// File: tb/tb_result_display_scan.sv
// Self-checking bench for result_display_scan (NUM_DIGITS=4, SCAN_DIV=8) against a queue-based model.
module tb_result_display_scan;

    localparam int N  = 4;
    localparam int SD = 8;
`ifdef DISPLAY_GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       result_valid;
    logic [3:0] result_in;
    logic       clear;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] history_count;

    int tests = 0;
    int fails = 0;

    result_display_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .result_valid(result_valid), .result_in(result_in),
        .clear(clear), .an(an), .seg(seg), .dp(dp), .history_count(history_count)
    );

    always #5 clk = ~clk;

    // Model: newest-first queue of codes, the queue as it stood one edge ago, and edges since reset.
    logic [3:0] hist[$];
    logic [3:0] prev_h[$];
    int         n_cyc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            prev_h.delete();
            n_cyc = 0;
        end else begin
            prev_h = hist;
            n_cyc++;
            if (clear) hist.delete();
            if (result_valid) begin
                hist.push_front(result_in);
                if (hist.size() > N) void'(hist.pop_back());
            end
        end
    end

    function automatic logic [6:0] dec(input logic [3:0] c);
        logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (c < 10) return pat[c];
        if (c == 10) return 7'h3F;
        return 7'h7F;
    endfunction

    // Expected {an, seg, dp, history_count} after the most recent edge.
    function automatic logic [14:0] expected();
        logic [3:0] a = 4'hF;
        logic [6:0] s = 7'h7F;
        logic       d = 1'b0;
        int dig, pos;
        if (n_cyc > 0) begin
            dig = ((n_cyc - 1) / SD) % N;
            pos = (n_cyc - 1) % SD;
            if (!(GHOST && pos < 2)) begin
                a = ~(4'b0001 << dig);
                if (dig < prev_h.size()) begin
                    s = dec(prev_h[dig]);
                    d = (dig == 0);
                end
            end
        end
        return {a, s, d, 3'(hist.size())};
    endfunction

    task automatic pulse(input logic [3:0] c, input logic clr);
        result_valid = 1'b1;
        result_in    = c;
        clear        = clr;
        @(negedge clk);
        result_valid = 1'b0;
        clear        = 1'b0;
    endtask

    // Advance until digit d is displayed, a few clocks into its slot (past any blanking).
    task automatic wait_slot(input int d);
        for (int i = 0; i < 2 * N * SD; i++) begin
            @(negedge clk);
            if (n_cyc > 0 && ((n_cyc - 1) / SD) % N == d && (n_cyc - 1) % SD == 3) break;
        end
    endtask

    task automatic test_reset();
        pulse(4'd4, 1'b0);
        repeat (12) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        if ({an, seg, dp, history_count} !== {4'hF, 7'h7F, 1'b0, 3'd0}) begin
            fails++;
            $display("FAIL reset_async got an=%h seg=%h dp=%b cnt=%0d", an, seg, dp, history_count);
        end
        tests++;
        repeat (2) @(negedge clk);
        if ({an, seg, dp, history_count} !== {4'hF, 7'h7F, 1'b0, 3'd0}) begin
            fails++;
            $display("FAIL reset_held got an=%h seg=%h dp=%b cnt=%0d", an, seg, dp, history_count);
        end
        tests++;
        rst = 1'b0;
        for (int k = 0; k < N * SD; k++) begin
            @(negedge clk);
            if ({an, seg, dp, history_count} !== expected()) begin
                fails++;
                $display("FAIL reset_scan cyc=%0d got=%h exp=%h", n_cyc, {an, seg, dp, history_count}, expected());
            end
            tests++;
        end
    endtask

    task automatic test_sequence();
        logic [3:0] codes [4] = '{4'd3, 4'd7, 4'd10, 4'd12};
        logic [6:0] want  [4] = '{7'h7F, 7'h3F, 7'h78, 7'h30};
        foreach (codes[i]) begin
            pulse(codes[i], 1'b0);
            repeat (2) @(negedge clk);
        end
        if (history_count !== 3'd4) begin
            fails++;
            $display("FAIL seq_count got=%0d exp=4", history_count);
        end
        tests++;
        for (int d = 0; d < N; d++) begin
            wait_slot(d);
            if (seg !== want[d] || dp !== (d == 0)) begin
                fails++;
                $display("FAIL seq_slot%0d got seg=%h dp=%b exp seg=%h", d, seg, dp, want[d]);
            end
            tests++;
        end
    endtask

    task automatic test_overflow();
        pulse(4'd5, 1'b0);
        if (history_count !== 3'd4) begin
            fails++;
            $display("FAIL ovf_count got=%0d exp=4", history_count);
        end
        tests++;
        wait_slot(0);
        if (seg !== 7'h12) begin
            fails++;
            $display("FAIL ovf_slot0 got=%h exp=12", seg);
        end
        tests++;
        wait_slot(3);
        if (seg !== 7'h78) begin
            fails++;
            $display("FAIL ovf_slot3 got=%h exp=78", seg);
        end
        tests++;
    endtask

    task automatic test_simultaneous();
        pulse(4'd1, 1'b1);
        if (history_count !== 3'd1) begin
            fails++;
            $display("FAIL simul_count got=%0d exp=1", history_count);
        end
        tests++;
        for (int d = 0; d < N; d++) begin
            wait_slot(d);
            if (seg !== ((d == 0) ? 7'h79 : 7'h7F)) begin
                fails++;
                $display("FAIL simul_slot%0d got=%h", d, seg);
            end
            tests++;
        end
    endtask

    task automatic test_back_to_back();
        result_valid = 1'b1;
        result_in    = 4'd2;
        @(negedge clk);
        result_in    = 4'd9;
        @(negedge clk);
        result_valid = 1'b0;
        if (history_count !== 3'd3) begin
            fails++;
            $display("FAIL b2b_count got=%0d exp=3", history_count);
        end
        tests++;
        wait_slot(0);
        if (seg !== 7'h10) begin
            fails++;
            $display("FAIL b2b_slot0 got=%h exp=10", seg);
        end
        tests++;
        wait_slot(1);
        if (seg !== 7'h24) begin
            fails++;
            $display("FAIL b2b_slot1 got=%h exp=24", seg);
        end
        tests++;
    endtask

    task automatic test_ghost();
        int blanks;
        for (int i = 0; i < 2 * N * SD; i++) begin
            @(negedge clk);
            if ((n_cyc - 1) % SD == SD - 1) break;
        end
        for (int s = 0; s < N; s++) begin
            blanks = 0;
            for (int k = 0; k < SD; k++) begin
                @(negedge clk);
                if (an === 4'hF) blanks++;
            end
            if (blanks != (GHOST ? 2 : 0)) begin
                fails++;
                $display("FAIL ghost_slot%0d blank clocks got=%0d exp=%0d", s, blanks, GHOST ? 2 : 0);
            end
            tests++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ({an, seg, dp, history_count} !== expected()) begin
                fails++;
                $display("FAIL random cyc=%0d got=%h exp=%h", n_cyc, {an, seg, dp, history_count}, expected());
            end
            tests++;
            result_valid = ($urandom_range(0, 2) == 0);
            clear        = ($urandom_range(0, 15) == 0);
            result_in    = 4'($urandom_range(0, 15));
        end
        result_valid = 1'b0;
        clear        = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        result_valid = 1'b0;
        result_in    = 4'd0;
        clear        = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_sequence();
        test_overflow();
        test_simultaneous();
        test_back_to_back();
        test_ghost();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
